// File: rtl/wb_commit_queue.sv
// In-order writeback buffer: up to two results in, up to two out per cycle, plus one forwarding lookup port.
// Latency: one cycle from enqueue edge to write port; in_ready_o needs two free slots and drain_stall_i holds the head.
module wb_commit_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_a_i,
    input  logic [4:0]       in_addr_a_i,
    input  logic [31:0]      in_data_a_i,
    input  logic             in_valid_b_i,
    input  logic [4:0]       in_addr_b_i,
    input  logic [31:0]      in_data_b_i,
    output logic             in_ready_o,
    input  logic             drain_stall_i,
    output logic             we1_o,
    output logic [4:0]       waddr1_o,
    output logic [31:0]      wdata1_o,
    output logic             we2_o,
    output logic [4:0]       waddr2_o,
    output logic [31:0]      wdata2_o,
    input  logic [4:0]       fwd_raddr_i,
    output logic             fwd_hit_o,
    output logic [31:0]      fwd_data_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] TWO_C   = (PTR_W+1)'(2);

    logic [PTR_W:0]   head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] head_idx, head_nxt_idx, tail_idx, tail_nxt_idx;
    logic             push_a, push_b;
    logic [PTR_W:0]   n_push, n_pop;

    assign head_idx     = head_q[PTR_W-1:0];
    assign head_nxt_idx = head_idx + PTR_W'(1);
    assign tail_idx     = tail_q[PTR_W-1:0];
    assign tail_nxt_idx = tail_idx + PTR_W'(1);

    // Gated by rst so upstream sees "not ready" for the whole reset window.
    assign in_ready_o = rst && ((DEPTH_C - count_q) >= TWO_C);
    assign push_a     = in_ready_o && in_valid_a_i && (in_addr_a_i != 5'd0);
    assign push_b     = in_ready_o && in_valid_b_i && (in_addr_b_i != 5'd0);

    assign we1_o    = (count_q != '0) && !drain_stall_i;
    assign we2_o    = (count_q >= TWO_C) && !drain_stall_i;
    assign waddr1_o = we1_o ? addr_q[head_idx] : 5'd0;
    assign wdata1_o = we1_o ? data_q[head_idx] : 32'd0;
    assign waddr2_o = we2_o ? addr_q[head_nxt_idx] : 5'd0;
    assign wdata2_o = we2_o ? data_q[head_nxt_idx] : 32'd0;
    assign count_o  = count_q;

    assign n_push  = {{PTR_W{1'b0}}, push_a} + {{PTR_W{1'b0}}, push_b};
    assign n_pop   = {{PTR_W{1'b0}}, we1_o} + {{PTR_W{1'b0}}, we2_o};
    assign head_d  = head_q + n_pop;
    assign tail_d  = tail_q + n_push;
    assign count_d = count_q + n_push - n_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // B lands at tail when A was dropped (invalid or r0), otherwise right behind A.
    always_ff @(posedge clk) begin
        if (push_a) begin
            addr_q[tail_idx] <= in_addr_a_i;
            data_q[tail_idx] <= in_data_a_i;
        end
        if (push_b) begin
            if (push_a) begin
                addr_q[tail_nxt_idx] <= in_addr_b_i;
                data_q[tail_nxt_idx] <= in_data_b_i;
            end else begin
                addr_q[tail_idx] <= in_addr_b_i;
                data_q[tail_idx] <= in_data_b_i;
            end
        end
    end

    // Walk oldest to newest so the last match (closest to tail) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        fwd_hit_o  = 1'b0;
        fwd_data_o = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_idx + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_q) && (fwd_raddr_i != 5'd0) &&
                (addr_q[idx] == fwd_raddr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_q[idx];
            end
        end
    end

endmodule

// File: doc/wb_commit_queue.md
Name: wb_commit_queue

Overview:
- In-order writeback buffer between the dual-issue execute/memory stages and the register file's two write ports.
- Accepts up to two completed results per cycle, holds them in program order, and drains up to two per cycle onto the regfile write ports (port 1 = older, port 2 = younger).
- Provides one forwarding lookup port so decode can see results that are still buffered and not yet written.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 4.
- PTR_W, 3, log2(DEPTH); pointer width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid_a_i  in  1  older incoming result is valid.
- in_addr_a_i  in  5  destination register of the older result.
- in_data_a_i  in  32  data of the older result.
- in_valid_b_i  in  1  younger incoming result is valid.
- in_addr_b_i  in  5  destination register of the younger result.
- in_data_b_i  in  32  data of the younger result.
- in_ready_o  out  1  queue can accept two results this cycle.
- drain_stall_i  in  1  hold the head; no pops this cycle.
- we1_o  out  1  write enable, older head entry.
- waddr1_o  out  5  write address, older head entry.
- wdata1_o  out  32  write data, older head entry.
- we2_o  out  1  write enable, second entry.
- waddr2_o  out  5  write address, second entry.
- wdata2_o  out  32  write data, second entry.
- fwd_raddr_i  in  5  forwarding lookup address.
- fwd_hit_o  out  1  a buffered entry matches fwd_raddr_i.
- fwd_data_o  out  32  data of the newest matching entry.
- count_o  out  PTR_W+1  current occupancy.

Behaviour:
- Storage: circular buffer of {addr[4:0], data[31:0]}, with head pointer, tail pointer and count, all PTR_W+1 wide. Pointers wrap modulo DEPTH.
- Reset (rst=0, asynchronous):
  - head, tail and count go to 0.
  - All outputs are 0: we1_o=we2_o=0, in_ready_o=0 while rst=0, fwd_hit_o=0.
  - Entry contents are don't-care.
  - A reset asserted mid-operation discards every buffered entry; nothing is written out.
- in_ready_o = (DEPTH - count) >= 2, combinational from registered count.
- Enqueue (only when in_ready_o=1; upstream must not present valid while ready=0; inputs presented while ready=0 are ignored):
  - Results with addr==0 are accepted but not stored (r0 is hardwired).
  - Surviving results are written at tail and tail+1 in order A then B.
  - tail advances by 0, 1 or 2.
  - Valid B alone is legal and is stored at tail.
- Drain (combinational outputs):
  - we1_o = (count>=1) & !drain_stall_i, driven from entry[head].
  - we2_o = (count>=2) & !drain_stall_i, driven from entry[head+1].
  - On the same clock edge, head advances by we1_o + we2_o.
  - Latency: a result accepted at edge N is visible on the write ports during the cycle after edge N, at the earliest.
  - Same-address pairs are driven as-is. The regfile gives port 2 priority, so the younger entry wins, which matches program order.
- Simultaneous enqueue and drain in one cycle: count_next = count + pushes - pops.
  - The full condition uses the pre-update count.
  - Drain is never blocked by enqueue.
- Forwarding:
  - Combinational search over all valid entries (head to tail-1).
  - fwd_hit_o is asserted for the match closest to tail; fwd_data_o is that entry's data.
  - fwd_raddr_i==0 gives hit=0 and data=0.
  - Entries being popped this cycle still count as hits, because the regfile write lands only at the edge.
  - Incoming in_*_i results are not searched.
- Wrap-around: entry index = pointer[PTR_W-1:0]. head+1 must wrap correctly when head = DEPTH-1.
- Invariants: count <= DEPTH always. count==0 implies we1_o=we2_o=0.

Test Plan:
- Reset then single push: A={r5, 0x11111111} at edge 1 -> cycle 2 shows we1_o=1, waddr1_o=5, wdata1_o=0x11111111, we2_o=0; count_o returns to 0 after edge 2.
- Dual push with WAW: A={r3, 0xA}, B={r3, 0xB} -> next cycle we1/we2 both 1 with addr 3, wdata1=0xA and wdata2=0xB; fwd_raddr_i=3 gives fwd_hit_o=1 and fwd_data_o=0xB in that cycle.
- Fill under stall: drain_stall_i=1, push two results per cycle for 4 cycles (DEPTH=8) -> count_o=8 and in_ready_o=0; release stall -> 4 cycles of dual writes in exact push order; in_ready_o=1 once count<=6.
- r0 filter: push A={r0, 0xDEAD}, B={r7, 0x7} -> only r7 is buffered (count_o=1); fwd_raddr_i=0 gives hit=0.
- Wrap-around: run pointer head to index 7 with 3 entries queued -> pops read indices 7 then 0, data order preserved, no duplicate or lost writes over 100 random push/stall cycles checked against a reference queue model.
- Asynchronous reset mid-drain: count_o=5, assert rst low between edges -> we1_o/we2_o drop immediately and count_o=0; after release, the first push appears normally.
